rv32i_core: RTL and testbench

Single-cycle RV32I integer core: fetches, decodes, executes and retires one instruction per clock. Sits between an external combinational instruction memory and a data memory that reads combinationally and writes on the clock edge with a byte mask. Contains the PC, a 32×32 register file, ALU, branch unit, immediate generator and load/store lane logic.

---
 rtl/rv32i_pkg.sv | 79 +++++++
 rtl/rv32i_core_regfile.sv | 32 +++
 rtl/rv32i_core.sv | 178 +++++++++++++++++
 tb/tb_rv32i_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, decode enums and the immediate helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  // Opcode bits [6:0] are never part of an immediate, so only [31:7] is taken.
  function automatic logic [31:0] gen_imm(input logic [31:7] ins, input imm_type_e t);
    logic [31:0] imm;
    imm = '0;
    case (t)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // alt selects SUB over ADD and SRA over SRL (instruction bit 30).
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_core_regfile.sv
// 32x32 integer register file, two combinational read ports, one write port; x0 is hardwired zero.
// Latency: reads combinational, write visible after the rising edge.
// Backpressure: none; a write is accepted every cycle it is enabled.
module rv32i_core_regfile
  import rv32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] rf [0:31];

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : rf[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : rf[ra2_i];

  // Reset clears every register and overrides any write in the same cycle; x0 writes dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      rf[wa_i] <= wd_i;
    end
  end

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory access and writeback in one clock.
// Latency: one instruction retires per rising edge; memories are combinational-read.
// Backpressure: none; the core never stalls, so both memories must answer within the cycle.
module rv32i_core
  import rv32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_A_o,
  input  logic [31:0] imem_RD_i,
  output logic [31:0] dmem_A_o,
  output logic [31:0] dmem_WD_o,
  output logic        dmem_WE_o,
  output logic [3:0]  dmem_WMASK_o,
  input  logic [31:0] dmem_RD_i
);

  logic [31:0] PC, pc_d;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1_a, rs2_a;
  logic [2:0]  funct3;
  logic        funct7_b5;
  imm_type_e   imm_type;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        a_pc, b_imm, rd_we, is_branch, is_jal, is_jalr, is_store, br_cond;
  logic [31:0] rs1_v, rs2_v, imm, op_a, op_b, alu_res, load_v, wb_v;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign opcode    = imem_RD_i[6:0];
  assign rd        = imem_RD_i[11:7];
  assign funct3    = imem_RD_i[14:12];
  assign rs1_a     = imem_RD_i[19:15];
  assign rs2_a     = imem_RD_i[24:20];
  assign funct7_b5 = imem_RD_i[30];

  rv32i_core_regfile rf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ra1_i (rs1_a),
    .ra2_i (rs2_a),
    .rd1_o (rs1_v),
    .rd2_o (rs2_v),
    .we_i  (rd_we),
    .wa_i  (rd),
    .wd_i  (wb_v)
  );

  // Decoder: anything not listed (FENCE, ECALL, EBREAK, unknown) falls through as a NOP.
  always_comb begin
    imm_type  = IMM_I;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    a_pc      = 1'b0;
    b_imm     = 1'b1;
    rd_we     = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_store  = 1'b0;
    case (opcode)
      OPC_LUI:    begin imm_type = IMM_U; alu_op = ALU_PASSB; rd_we = 1'b1; end
      OPC_AUIPC:  begin imm_type = IMM_U; a_pc = 1'b1; rd_we = 1'b1; end
      OPC_JAL:    begin imm_type = IMM_J; is_jal = 1'b1; rd_we = 1'b1; wb_sel = WB_PC4; end
      OPC_JALR:   begin is_jalr = 1'b1; rd_we = 1'b1; wb_sel = WB_PC4; end
      OPC_BRANCH: begin imm_type = IMM_B; is_branch = 1'b1; end
      OPC_LOAD:   begin rd_we = 1'b1; wb_sel = WB_MEM; end
      OPC_STORE:  begin imm_type = IMM_S; is_store = 1'b1; end
      OPC_OP_IMM: begin
        alu_op = alu_from_f3(funct3, (funct3 == F3_SR) && funct7_b5);
        rd_we  = 1'b1;
      end
      OPC_OP:     begin alu_op = alu_from_f3(funct3, funct7_b5); b_imm = 1'b0; rd_we = 1'b1; end
      OPC_MISC_MEM, OPC_SYSTEM: begin end
      default:    begin end
    endcase
  end

  assign imm  = gen_imm(imem_RD_i[31:7], imm_type);
  assign op_a = a_pc ? PC : rs1_v;
  assign op_b = b_imm ? imm : rs2_v;

  // ALU; its sum doubles as the load/store effective address and the JALR target.
  always_comb begin
    case (alu_op)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {31'd0, op_a < op_b};
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = op_a + op_b;
    endcase
  end

  // Branch comparator on the raw register operands.
  always_comb begin
    case (funct3)
      F3_BEQ:  br_cond = (rs1_v == rs2_v);
      F3_BNE:  br_cond = (rs1_v != rs2_v);
      F3_BLT:  br_cond = ($signed(rs1_v) < $signed(rs2_v));
      F3_BGE:  br_cond = ($signed(rs1_v) >= $signed(rs2_v));
      F3_BLTU: br_cond = (rs1_v < rs2_v);
      F3_BGEU: br_cond = (rs1_v >= rs2_v);
      default: br_cond = 1'b0;
    endcase
  end

  // Next-PC selection; JALR clears bit 0 of its target.
  always_comb begin
    pc_d = PC + 32'd4;
    if (is_jal || (is_branch && br_cond)) pc_d = PC + imm;
    else if (is_jalr)                     pc_d = {alu_res[31:1], 1'b0};
  end

  // Store lanes: data replicated across lanes, mask picks them; silenced while in reset.
  always_comb begin
    dmem_WMASK_o = 4'b0000;
    dmem_WD_o    = rs2_v;
    case (funct3[1:0])
      2'b00: begin
        dmem_WMASK_o = 4'b0001 << alu_res[1:0];
        dmem_WD_o    = {4{rs2_v[7:0]}};
      end
      2'b01: begin
        dmem_WMASK_o = alu_res[1] ? 4'b1100 : 4'b0011;
        dmem_WD_o    = {2{rs2_v[15:0]}};
      end
      default: dmem_WMASK_o = 4'b1111;
    endcase
    if (!is_store || !rst_i) dmem_WMASK_o = 4'b0000;
  end

  assign dmem_WE_o = is_store && rst_i;
  assign dmem_A_o  = alu_res;
  assign imem_A_o  = PC;

  // Load lane extraction and extension.
  always_comb begin
    ld_byte = dmem_RD_i[7:0];
    case (alu_res[1:0])
      2'b01:   ld_byte = dmem_RD_i[15:8];
      2'b10:   ld_byte = dmem_RD_i[23:16];
      2'b11:   ld_byte = dmem_RD_i[31:24];
      default: ld_byte = dmem_RD_i[7:0];
    endcase
    ld_half = alu_res[1] ? dmem_RD_i[31:16] : dmem_RD_i[15:0];
    case (funct3)
      F3_LB:   load_v = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   load_v = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  load_v = {24'd0, ld_byte};
      F3_LHU:  load_v = {16'd0, ld_half};
      default: load_v = dmem_RD_i;
    endcase
  end

  // Writeback source select.
  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_v = load_v;
      WB_PC4:  wb_v = PC + 32'd4;
      default: wb_v = alu_res;
    endcase
  end

  // PC register; reset wins over any jump or branch in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) PC <= '0;
    else        PC <= pc_d;
  end

endmodule

// File: tb/tb_rv32i_core.sv
`timescale 1ns/1ps
module tb_rv32i_core;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] imem_A_o, imem_RD_i, dmem_A_o, dmem_WD_o, dmem_RD_i;
  logic        dmem_WE_o;
  logic [3:0]  dmem_WMASK_o;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];

  typedef struct {
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] d;
  } st_t;

  logic [31:0] pc_q [$];
  st_t         st_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  rv32i_core dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem_A_o     (imem_A_o),
    .imem_RD_i    (imem_RD_i),
    .dmem_A_o     (dmem_A_o),
    .dmem_WD_o    (dmem_WD_o),
    .dmem_WE_o    (dmem_WE_o),
    .dmem_WMASK_o (dmem_WMASK_o),
    .dmem_RD_i    (dmem_RD_i)
  );

  assign imem_RD_i = imem[imem_A_o[7:2]];
  assign dmem_RD_i = dmem[dmem_A_o[7:2]];

  always @(posedge clk) begin
    if (dmem_WE_o) begin
      for (int i = 0; i < 4; i++)
        if (dmem_WMASK_o[i]) dmem[dmem_A_o[7:2]][8*i +: 8] <= dmem_WD_o[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Retired-PC scoreboard: one expected PC per clock while running.
  always @(posedge clk) begin
    #1;
    if (rst_i && pc_q.size() != 0) check("pc", imem_A_o, pc_q.pop_front());
  end

  // Store scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (dmem_WE_o) begin
      if (st_q.size() == 0) begin
        check("st_unexpected", 32'(st_q.size()), 32'd1);
      end else begin
        st_t e;
        e = st_q.pop_front();
        check("st_addr", dmem_A_o, e.a);
        check("st_mask", {28'd0, dmem_WMASK_o}, {28'd0, e.m});
        check("st_data", dmem_WD_o, e.d);
      end
    end else begin
      check("wmask_idle", {28'd0, dmem_WMASK_o}, 32'd0);
    end
  end

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
    return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
         | ((imm & 'h1F) << 7) | 'h23;
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
         | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    return (imm20 << 12) | (rd << 7) | op;
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) | (((imm >> 11) & 1) << 20)
         | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
  endfunction

  // Put the core in reset for one edge and blank the instruction memory.
  task automatic start_prog();
    rst_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  task automatic run_prog(input int cycles);
    rst_i = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("pc_q_drained", 32'(pc_q.size()), 32'd0);
  endtask

  task automatic push_pcs(input logic [31:0] pcs [$]);
    foreach (pcs[i]) pc_q.push_back(pcs[i]);
  endtask

  initial begin
    rst_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'h0000_0013;
      dmem[i] = 32'h0;
    end

    // Reset with a store sitting at PC 0: memory must stay untouched.
    imem[0] = enc_s(0, 0, 0, 2);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_we", {31'd0, dmem_WE_o}, 32'd0);
    check("rst_mask", {28'd0, dmem_WMASK_o}, 32'd0);
    check("rst_imem_a", imem_A_o, 32'd0);
    check("rst_pc", dut.PC, 32'd0);

    // ALU, upper-immediate and jump program.
    start_prog();
    imem['h00>>2] = enc_i(-5, 0, 0, 1, 'h13);
    imem['h04>>2] = enc_i(3, 0, 0, 2, 'h13);
    imem['h08>>2] = enc_r('h20, 2, 1, 0, 3, 'h33);
    imem['h0C>>2] = enc_r('h20, 2, 1, 5, 4, 'h33);
    imem['h10>>2] = enc_u('h12345, 6, 'h37);
    imem['h14>>2] = enc_u(1, 7, 'h17);
    imem['h18>>2] = enc_j(8, 8);
    imem['h1C>>2] = enc_i(99, 0, 0, 13, 'h13);
    imem['h20>>2] = enc_r(0, 1, 2, 3, 5, 'h33);
    imem['h24>>2] = enc_i(7, 1, 0, 0, 'h13);
    imem['h28>>2] = enc_i('h35, 0, 0, 14, 'h13);
    imem['h2C>>2] = enc_i(0, 14, 0, 15, 'h67);
    imem['h30>>2] = enc_i(1, 0, 0, 16, 'h13);
    imem['h34>>2] = enc_i(2, 0, 0, 17, 'h13);
    imem['h38>>2] = enc_r(0, 2, 1, 2, 9, 'h33);
    imem['h3C>>2] = enc_i(28, 1, 5, 10, 'h13);
    imem['h40>>2] = enc_i(4, 2, 1, 11, 'h13);
    imem['h44>>2] = enc_i(-1, 1, 4, 12, 'h13);
    imem['h48>>2] = enc_r(0, 2, 1, 7, 18, 'h33);
    imem['h4C>>2] = enc_r(0, 2, 3, 6, 19, 'h33);
    imem['h50>>2] = enc_i('h402, 3, 5, 20, 'h13);
    imem['h54>>2] = enc_i(-1, 2, 3, 21, 'h13);
    imem['h58>>2] = enc_j(0, 0);
    push_pcs('{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h20, 32'h24, 32'h28,
               32'h2C, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50,
               32'h54, 32'h58, 32'h58, 32'h58});
    check("pc_after_release", dut.PC, 32'd0);
    run_prog(22);
    check("x0", dut.rf.rf[0], 32'h0);
    check("x1", dut.rf.rf[1], 32'hFFFF_FFFB);
    check("x3_sub", dut.rf.rf[3], 32'hFFFF_FFF8);
    check("x4_sra", dut.rf.rf[4], 32'hFFFF_FFFF);
    check("x5_sltu", dut.rf.rf[5], 32'h1);
    check("x6_lui", dut.rf.rf[6], 32'h1234_5000);
    check("x7_auipc", dut.rf.rf[7], 32'h0000_1014);
    check("x8_jal", dut.rf.rf[8], 32'h0000_001C);
    check("x13_skip", dut.rf.rf[13], 32'h0);
    check("x15_jalr", dut.rf.rf[15], 32'h0000_0030);
    check("x16_skip", dut.rf.rf[16], 32'h0);
    check("x17", dut.rf.rf[17], 32'h2);
    check("x9_slt", dut.rf.rf[9], 32'h1);
    check("x10_srli", dut.rf.rf[10], 32'h0000_000F);
    check("x11_slli", dut.rf.rf[11], 32'h0000_0030);
    check("x12_xori", dut.rf.rf[12], 32'h0000_0004);
    check("x18_and", dut.rf.rf[18], 32'h0000_0003);
    check("x19_or", dut.rf.rf[19], 32'hFFFF_FFFB);
    check("x20_srai", dut.rf.rf[20], 32'hFFFF_FFFE);
    check("x21_sltiu", dut.rf.rf[21], 32'h1);

    // Reset mid-program clears PC and every register.
    rst_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_pc", dut.PC, 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("midrst_x%0d", i), dut.rf.rf[i], 32'd0);

    // Branch program.
    start_prog();
    imem['h00>>2] = enc_i(-1, 0, 0, 1, 'h13);
    imem['h04>>2] = enc_i(1, 0, 0, 2, 'h13);
    imem['h08>>2] = enc_b(8, 1, 1, 0);
    imem['h0C>>2] = enc_i(1, 0, 0, 20, 'h13);
    imem['h10>>2] = enc_b(8, 2, 1, 0);
    imem['h14>>2] = enc_b(8, 2, 1, 4);
    imem['h18>>2] = enc_i(1, 0, 0, 21, 'h13);
    imem['h1C>>2] = enc_b(8, 2, 1, 6);
    imem['h20>>2] = enc_b(8, 1, 2, 5);
    imem['h24>>2] = enc_i(1, 0, 0, 22, 'h13);
    imem['h28>>2] = enc_b(8, 2, 1, 7);
    imem['h2C>>2] = enc_i(1, 0, 0, 23, 'h13);
    imem['h30>>2] = enc_j(0, 0);
    push_pcs('{32'h04, 32'h08, 32'h10, 32'h14, 32'h1C, 32'h20, 32'h28, 32'h30, 32'h30, 32'h30});
    run_prog(10);
    check("br_x20", dut.rf.rf[20], 32'h0);
    check("br_x21", dut.rf.rf[21], 32'h0);
    check("br_x22", dut.rf.rf[22], 32'h0);
    check("br_x23", dut.rf.rf[23], 32'h0);

    // Store / load program.
    start_prog();
    imem['h00>>2] = enc_u('h11223, 1, 'h37);
    imem['h04>>2] = enc_i('h344, 1, 0, 1, 'h13);
    imem['h08>>2] = enc_i('h40, 0, 0, 2, 'h13);
    imem['h0C>>2] = enc_s(0, 1, 2, 2);
    imem['h10>>2] = enc_i('hAA, 0, 0, 3, 'h13);
    imem['h14>>2] = enc_s(1, 3, 2, 0);
    imem['h18>>2] = enc_u('hC, 4, 'h37);
    imem['h1C>>2] = enc_i(-273, 4, 0, 4, 'h13);
    imem['h20>>2] = enc_s(2, 4, 2, 1);
    imem['h24>>2] = enc_i(1, 2, 0, 5, 'h03);
    imem['h28>>2] = enc_i(1, 2, 4, 6, 'h03);
    imem['h2C>>2] = enc_i(2, 2, 1, 7, 'h03);
    imem['h30>>2] = enc_i(2, 2, 5, 8, 'h03);
    imem['h34>>2] = enc_i(0, 2, 2, 9, 'h03);
    imem['h38>>2] = enc_s(0, 3, 2, 1);
    imem['h3C>>2] = enc_i(0, 2, 2, 10, 'h03);
    imem['h40>>2] = enc_j(0, 0);
    st_q.push_back('{32'h40, 4'b1111, 32'h1122_3344});
    st_q.push_back('{32'h41, 4'b0010, 32'hAAAA_AAAA});
    st_q.push_back('{32'h42, 4'b1100, 32'hBEEF_BEEF});
    st_q.push_back('{32'h40, 4'b0011, 32'h00AA_00AA});
    push_pcs('{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24,
               32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h40});
    run_prog(17);
    check("st_q_drained", 32'(st_q.size()), 32'd0);
    check("lb", dut.rf.rf[5], 32'hFFFF_FFAA);
    check("lbu", dut.rf.rf[6], 32'h0000_00AA);
    check("lh", dut.rf.rf[7], 32'hFFFF_BEEF);
    check("lhu", dut.rf.rf[8], 32'h0000_BEEF);
    check("lw", dut.rf.rf[9], 32'hBEEF_AA44);
    check("st_then_ld", dut.rf.rf[10], 32'hBEEF_00AA);
    check("mem_0x40", dmem['h40>>2], 32'hBEEF_00AA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
